// File: rtl/keypad_digit_entry.sv
// keypad_digit_entry
//   Front end for the four-digit combination lock. Eight raw, bouncy,
//   active-high push-button lines are synchronised and debounced, and each
//   clean single-key press becomes a 3-bit digit with a one-cycle
//   digit_valid strobe. Multi-key patterns raise a one-cycle multi_key pulse.
//
//   Optional feature, macro KEYPAD_TIMEOUT_EN:
//     defined   - an inter-digit timer pulses entry_timeout once when no new
//                 digit follows within TIMEOUT_CYCLES idle cycles.
//     undefined - no timer state exists and entry_timeout is tied low.
//
//   Reset is synchronous and active-high; every output is registered.

module keypad_digit_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,   // legal 2..65535
   parameter int unsigned TIMEOUT_CYCLES  = 1000  // legal 2..2^20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] key_raw,
   output logic [2:0] digit,
   output logic       digit_valid,
   output logic       multi_key,
   output logic       entry_timeout,
   output logic       key_busy
);

   // Reject illegal configurations at elaboration time.
   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
       TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << 20)) begin : g_bad_param
      $error("keypad_digit_entry: DEBOUNCE_CYCLES or TIMEOUT_CYCLES out of range");
   end

   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_e;

   // Synchroniser flops; key_s_q is the only view of the keys used below.
   logic [7:0]  sync_meta_q;
   logic [7:0]  key_s_q;

   // FSM state, debounce counter and captured key pattern.
   state_e      state_q;
   logic [15:0] cnt_q;
   logic [7:0]  cap_q;

   // Registered outputs.
   logic [2:0]  digit_q;
   logic        digit_valid_q;
   logic        multi_key_q;
   logic        key_busy_q;

   // Decode of the captured pattern.
   logic        cap_onehot_d;
   logic [2:0]  cap_index_d;

   // Two-flop synchroniser on all eight asynchronous button lines.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta_q <= '0;
         key_s_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments make both flops sample the old
         // value of their source, giving a true two-stage chain; blocking
         // assignments here would collapse it into a single flop.
         sync_meta_q <= key_raw;
         key_s_q     <= sync_meta_q;
      end
   end

   // One-hot test and bit index of the captured pattern.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write,
      // so no path leaves it unassigned and no latch is inferred.
      cap_onehot_d = (cap_q != 8'd0) && ((cap_q & (cap_q - 8'd1)) == 8'd0);
      cap_index_d  = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (cap_q[i]) begin
            cap_index_d = 3'(i);
         end
      end
   end

   // Debounce FSM with registered digit, strobes and busy flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         cap_q         <= '0;
         digit_q       <= '0;
         digit_valid_q <= 1'b0;
         multi_key_q   <= 1'b0;
         key_busy_q    <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         digit_valid_q <= 1'b0;
         multi_key_q   <= 1'b0;

         case (state_q)
            IDLE: begin
               if (key_s_q != 8'd0) begin
                  cap_q      <= key_s_q;
                  cnt_q      <= '0;
                  state_q    <= DEBOUNCE;
                  key_busy_q <= 1'b1;
               end
            end

            DEBOUNCE: begin
               if (key_s_q != cap_q) begin
                  // Pattern moved before it settled: a bounce, emit nothing.
                  state_q    <= IDLE;
                  key_busy_q <= 1'b0;
               end else if (cnt_q == DB_LAST) begin
                  if (cap_onehot_d) begin
                     digit_q       <= cap_index_d;
                     digit_valid_q <= 1'b1;
                  end else begin
                     multi_key_q   <= 1'b1;
                  end
                  state_q <= HELD;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end

            HELD: begin
               // Pattern changes while held are ignored; no auto-repeat.
               if (key_s_q == 8'd0) begin
                  cnt_q   <= '0;
                  state_q <= RELEASE;
               end
            end

            RELEASE: begin
               if (key_s_q != 8'd0) begin
                  // Release bounce: the key is still considered held.
                  state_q <= HELD;
               end else if (cnt_q == DB_LAST) begin
                  state_q    <= IDLE;
                  key_busy_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end

            default: begin
               state_q    <= IDLE;
               key_busy_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef KEYPAD_TIMEOUT_EN
   localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

   logic [19:0] tcnt_q;
   logic        armed_q;
   logic        entry_timeout_q;

   // Inter-digit timer: armed by each digit, counts only while IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt_q          <= '0;
         armed_q         <= 1'b0;
         entry_timeout_q <= 1'b0;
      end else begin
         entry_timeout_q <= 1'b0;
         if (digit_valid_q) begin
            // The FSM is in HELD here, so the restart never races a count.
            armed_q <= 1'b1;
            tcnt_q  <= '0;
         end else if (armed_q && state_q == IDLE) begin
            if (tcnt_q == TO_LAST) begin
               entry_timeout_q <= 1'b1;
               armed_q         <= 1'b0;
            end else begin
               tcnt_q <= tcnt_q + 20'd1;
            end
         end
      end
   end

   assign entry_timeout = entry_timeout_q;
`else
   assign entry_timeout = 1'b0;
`endif

   assign digit       = digit_q;
   assign digit_valid = digit_valid_q;
   assign multi_key   = multi_key_q;
   assign key_busy    = key_busy_q;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// tb_keypad_digit_entry
//   Directed bench for keypad_digit_entry with DEBOUNCE_CYCLES=4 and
//   TIMEOUT_CYCLES=20. Inputs change 1 time unit after a rising edge; that
//   edge is E0 of the press. Outputs are sampled 1 time unit after edges.
//   Build with KEYPAD_TIMEOUT_EN defined to exercise the timeout path.

module tb_keypad_digit_entry;

   localparam int DB = 4;
   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] key_raw;
   logic [2:0] digit;
   logic       digit_valid;
   logic       multi_key;
   logic       entry_timeout;
   logic       key_busy;

   int checks   = 0;
   int failures = 0;

   // Pulse tallies gathered by the monitor, read as deltas by the stimulus.
   int         dv_seen = 0;
   int         mk_seen = 0;
   int         to_seen = 0;
   logic [2:0] dv_digits[$];

   always #5 clk = ~clk;

   keypad_digit_entry #(
      .DEBOUNCE_CYCLES(DB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .key_raw      (key_raw),
      .digit        (digit),
      .digit_valid  (digit_valid),
      .multi_key    (multi_key),
      .entry_timeout(entry_timeout),
      .key_busy     (key_busy)
   );

   // Count strobes mid-cycle so each one-cycle pulse is seen exactly once.
   always @(negedge clk) begin
      if (!reset) begin
         if (digit_valid) begin
            dv_seen <= dv_seen + 1;
            dv_digits.push_back(digit);
         end
         if (multi_key)     mk_seen <= mk_seen + 1;
         if (entry_timeout) to_seen <= to_seen + 1;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int b;
      int m;
      int t;
      int qbase;

      // Reset state.
      reset   = 1'b1;
      key_raw = 8'h00;
      step(3);
      check("rst_digit", digit, 0);
      check("rst_dv", digit_valid, 0);
      check("rst_mk", multi_key, 0);
      check("rst_to", entry_timeout, 0);
      check("rst_busy", key_busy, 0);
      reset = 1'b0;
      step(2);

      // 1. Clean press of key 2: strobe exactly at E7, busy drops at R7.
      b = dv_seen;
      key_raw = 8'h04;
      step(6);
      check("t1_dv_e6", digit_valid, 0);
      step(1);
      check("t1_dv_e7", digit_valid, 1);
      check("t1_digit", digit, 2);
      check("t1_busy_held", key_busy, 1);
      step(1);
      check("t1_dv_e8", digit_valid, 0);
      step(12);
      key_raw = 8'h00;
      step(6);
      check("t1_busy_r6", key_busy, 1);
      step(1);
      check("t1_busy_r7", key_busy, 0);
      step(3);
      check("t1_dv_count", dv_seen - b, 1);

      // 2. Bouncing key 3, then stable.
      b = dv_seen;
      for (int k = 0; k < 3; k++) begin
         key_raw = 8'h08;
         step(2);
         key_raw = 8'h00;
         step(2);
      end
      check("t2_bounce_quiet", dv_seen - b, 0);
      key_raw = 8'h08;
      step(6);
      check("t2_dv_e6", digit_valid, 0);
      step(1);
      check("t2_dv_e7", digit_valid, 1);
      check("t2_digit", digit, 3);
      step(8);
      key_raw = 8'h00;
      step(10);
      check("t2_dv_count", dv_seen - b, 1);

      // 3. Two keys together: multi_key only, digit keeps 3.
      b = dv_seen;
      m = mk_seen;
      key_raw = 8'h81;
      step(7);
      check("t3_mk_e7", multi_key, 1);
      check("t3_dv_e7", digit_valid, 0);
      step(1);
      check("t3_mk_e8", multi_key, 0);
      step(7);
      key_raw = 8'h00;
      step(10);
      check("t3_mk_count", mk_seen - m, 1);
      check("t3_dv_count", dv_seen - b, 0);
      check("t3_digit_kept", digit, 3);

      // 4. Lock sequence 0,1,2,3 with 12-cycle holds and gaps.
      b = dv_seen;
      qbase = dv_digits.size();
      for (int i = 0; i < 4; i++) begin
         key_raw = 8'h01 << i;
         step(7);
         check("t4_dv", digit_valid, 1);
         check("t4_digit", digit, i);
         step(5);
         key_raw = 8'h00;
         step(12);
      end
      check("t4_dv_count", dv_seen - b, 4);
      for (int i = 0; i < 4; i++) begin
         check("t4_order", dv_digits[qbase + i], i);
      end

      // 5. Press 5 and go idle: timeout 20 cycles after IDLE (edge R7).
      key_raw = 8'h20;
      step(7);
      check("t5_dv", digit_valid, 1);
      check("t5_digit", digit, 5);
      step(5);
      key_raw = 8'h00;
      t = to_seen;
`ifdef KEYPAD_TIMEOUT_EN
      step(26);
      check("t5_to_r26", entry_timeout, 0);
      step(1);
      check("t5_to_r27", entry_timeout, 1);
      step(1);
      check("t5_to_r28", entry_timeout, 0);
      step(60);
      check("t5_to_count", to_seen - t, 1);
`else
      step(28);
      check("t5_to_off", entry_timeout, 0);
      step(60);
      check("t5_to_count", to_seen - t, 0);
`endif

      // 6. Reset during DEBOUNCE of key 6, then a fresh press.
      b = dv_seen;
      key_raw = 8'h40;
      step(4);
      check("t6_busy_deb", key_busy, 1);
      reset   = 1'b1;
      key_raw = 8'h00;
      step(1);
      check("t6_rst_digit", digit, 0);
      check("t6_rst_dv", digit_valid, 0);
      check("t6_rst_mk", multi_key, 0);
      check("t6_rst_to", entry_timeout, 0);
      check("t6_rst_busy", key_busy, 0);
      reset = 1'b0;
      step(5);
      check("t6_no_dv", dv_seen - b, 0);
      key_raw = 8'h40;
      step(6);
      check("t6_dv_e6", digit_valid, 0);
      step(1);
      check("t6_dv_e7", digit_valid, 1);
      check("t6_digit", digit, 6);
      step(5);
      key_raw = 8'h00;
      step(10);
      check("t6_dv_count", dv_seen - b, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
